// File: rtl/atm_pkg.sv
// Shared definitions for the ATM account server and its session controller.
// Holds the server state encoding and the default widths / try limit that
// both sides of the ATM link agree on.
// Optional feature macro used elsewhere in this slice: ATM_PERSISTENT_LOCKOUT_EN.
package atm_pkg;

    localparam int DEF_BALANCE_WIDTH = 20;
    localparam int DEF_PSW_WIDTH     = 16;
    localparam int DEF_ID_WIDTH      = 2;
    localparam int DEF_NUM_ACCOUNTS  = 4;
    localparam int DEF_MAX_TRIES     = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_AUTH    = 2'd1,
        ST_SESSION = 2'd2,
        ST_REJECT  = 2'd3
    } atm_state_t;

endpackage

// File: rtl/atm_account_server_if.sv
// Signal bundle between the ATM session controller (master) and the bank-side
// account server (slave). Clock and reset are not part of the bundle.
//   controller -> server : card_in, card_id, timeout, psw_valid, psw_in,
//                          op_done, new_balance, prog_en, prog_id, prog_psw,
//                          prog_balance
//   server -> controller : psw_ok, wrong_psw, card_locked, current_balance,
//                          commit_ack, session_active, prog_err
interface atm_account_server_if
    import atm_pkg::*;
#(
    parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
    parameter int ID_WIDTH      = DEF_ID_WIDTH,
    parameter int PSW_WIDTH     = DEF_PSW_WIDTH
);
    logic                     card_in;
    logic [ID_WIDTH-1:0]      card_id;
    logic                     timeout;
    logic                     psw_valid;
    logic [PSW_WIDTH-1:0]     psw_in;
    logic                     op_done;
    logic [BALANCE_WIDTH-1:0] new_balance;
    logic                     prog_en;
    logic [ID_WIDTH-1:0]      prog_id;
    logic [PSW_WIDTH-1:0]     prog_psw;
    logic [BALANCE_WIDTH-1:0] prog_balance;

    logic                     psw_ok;
    logic                     wrong_psw;
    logic                     card_locked;
    logic [BALANCE_WIDTH-1:0] current_balance;
    logic                     commit_ack;
    logic                     session_active;
    logic                     prog_err;

    modport master (
        output card_in, card_id, timeout, psw_valid, psw_in, op_done, new_balance,
               prog_en, prog_id, prog_psw, prog_balance,
        input  psw_ok, wrong_psw, card_locked, current_balance, commit_ack,
               session_active, prog_err
    );

    modport slave (
        input  card_in, card_id, timeout, psw_valid, psw_in, op_done, new_balance,
               prog_en, prog_id, prog_psw, prog_balance,
        output psw_ok, wrong_psw, card_locked, current_balance, commit_ack,
               session_active, prog_err
    );
endinterface

// File: rtl/atm_account_bank.sv
// Account register file: NUM_ACCOUNTS x (password, balance, lock bit).
// Flop-based so that reset clears every entry.
// Ports:
//   clk, rst         clock; asynchronous active-low reset
//   rd_id            asynchronous read index -> rd_psw, rd_balance
//   lock_bits        lock bit of every entry (all zero without the macro)
//   wr_en/wr_id      single write port; always writes balance, password only
//                    when wr_psw_en, clears lock when wr_clr_lock
//   lock_set/lock_id set the lock bit of one entry
// Macro ATM_PERSISTENT_LOCKOUT_EN: when undefined no lock storage exists.
module atm_account_bank
    import atm_pkg::*;
#(
    parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
    parameter int PSW_WIDTH     = DEF_PSW_WIDTH,
    parameter int ID_WIDTH      = DEF_ID_WIDTH,
    parameter int NUM_ACCOUNTS  = DEF_NUM_ACCOUNTS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [ID_WIDTH-1:0]      rd_id,
    output logic [PSW_WIDTH-1:0]     rd_psw,
    output logic [BALANCE_WIDTH-1:0] rd_balance,
    output logic [NUM_ACCOUNTS-1:0]  lock_bits,
    input  logic                     wr_en,
    input  logic [ID_WIDTH-1:0]      wr_id,
    input  logic                     wr_psw_en,
    input  logic [PSW_WIDTH-1:0]     wr_psw,
    input  logic [BALANCE_WIDTH-1:0] wr_balance,
    input  logic                     wr_clr_lock,
    input  logic                     lock_set,
    input  logic [ID_WIDTH-1:0]      lock_id
);
    localparam logic [ID_WIDTH:0] NUM_ID = (ID_WIDTH+1)'(NUM_ACCOUNTS);

    logic [PSW_WIDTH-1:0]     psw_arr [NUM_ACCOUNTS];
    logic [BALANCE_WIDTH-1:0] bal_arr [NUM_ACCOUNTS];
    logic                     rd_ok;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ACCOUNTS; gi++) begin : g_entry
            localparam logic [ID_WIDTH-1:0] ENTRY_ID = ID_WIDTH'(gi);
            logic [PSW_WIDTH-1:0]     psw_reg;
            logic [BALANCE_WIDTH-1:0] bal_reg;
            logic                     wr_hit;

            assign wr_hit = wr_en && (wr_id == ENTRY_ID);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    psw_reg <= '0;
                    bal_reg <= '0;
                end else if (wr_hit) begin
                    bal_reg <= wr_balance;
                    if (wr_psw_en) begin
                        psw_reg <= wr_psw;
                    end
                end
            end

            assign psw_arr[gi] = psw_reg;
            assign bal_arr[gi] = bal_reg;

`ifdef ATM_PERSISTENT_LOCKOUT_EN
            logic lock_reg;
            // Clear (provisioning) and set (lockout) never coincide: one is
            // only issued from IDLE, the other only from AUTH.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lock_reg <= 1'b0;
                end else if (wr_hit && wr_clr_lock) begin
                    lock_reg <= 1'b0;
                end else if (lock_set && (lock_id == ENTRY_ID)) begin
                    lock_reg <= 1'b1;
                end
            end
            assign lock_bits[gi] = lock_reg;
`else
            assign lock_bits[gi] = 1'b0;
`endif
        end
    endgenerate

`ifndef ATM_PERSISTENT_LOCKOUT_EN
    logic unused_lock_inputs;
    assign unused_lock_inputs = ^{wr_clr_lock, lock_set, lock_id};
`endif

    assign rd_ok      = {1'b0, rd_id} < NUM_ID;
    assign rd_psw     = rd_ok ? psw_arr[rd_id] : '0;
    assign rd_balance = rd_ok ? bal_arr[rd_id] : '0;

endmodule

// File: rtl/atm_account_server.sv
// Bank-side responder for the ATM session controller: authenticates a card's
// password, serves the account balance, accepts balance commits, tracks
// failed attempts and supports account provisioning while no card is present.
// Ports:
//   clk, rst  clock; asynchronous active-low reset
//   bus       atm_account_server_if.slave (all handshake/data signals)
// All outputs are registered.
// Macro ATM_PERSISTENT_LOCKOUT_EN: exhausting the tries locks the account
// until it is re-provisioned; undefined, the lockout lasts only one insertion.
module atm_account_server
    import atm_pkg::*;
#(
    parameter int BALANCE_WIDTH = DEF_BALANCE_WIDTH,
    parameter int NUM_ACCOUNTS  = DEF_NUM_ACCOUNTS,
    parameter int ID_WIDTH      = DEF_ID_WIDTH,
    parameter int PSW_WIDTH     = DEF_PSW_WIDTH,
    parameter int MAX_TRIES     = DEF_MAX_TRIES
) (
    input logic                 clk,
    input logic                 rst,
    atm_account_server_if.slave bus
);
    localparam int                TRY_W   = $clog2(MAX_TRIES + 1);
    localparam logic [TRY_W-1:0]  TRY_MAX = TRY_W'(MAX_TRIES);
    localparam logic [ID_WIDTH:0] NUM_ID  = (ID_WIDTH+1)'(NUM_ACCOUNTS);

    atm_state_t               state_reg, state_next;
    logic [ID_WIDTH-1:0]      id_reg, id_next;
    logic [TRY_W-1:0]         tries_reg, tries_next, tries_inc;
    logic                     psw_ok_reg, psw_ok_next;
    logic                     wrong_psw_reg, wrong_psw_next;
    logic                     card_locked_reg, card_locked_next;
    logic                     commit_ack_reg, commit_ack_next;
    logic                     session_active_reg, session_active_next;
    logic                     prog_err_reg, prog_err_next;
    logic [BALANCE_WIDTH-1:0] balance_reg, balance_next;

    logic                     abort, commit, card_ok, prog_ok;
    logic [PSW_WIDTH-1:0]     rd_psw;
    logic [BALANCE_WIDTH-1:0] rd_balance;
    logic [NUM_ACCOUNTS-1:0]  lock_bits;
    logic                     wr_en, wr_psw_en, wr_clr_lock, lock_set;
    logic [ID_WIDTH-1:0]      wr_id;
    logic [PSW_WIDTH-1:0]     wr_psw;
    logic [BALANCE_WIDTH-1:0] wr_balance;

    atm_account_bank #(
        .BALANCE_WIDTH (BALANCE_WIDTH),
        .PSW_WIDTH     (PSW_WIDTH),
        .ID_WIDTH      (ID_WIDTH),
        .NUM_ACCOUNTS  (NUM_ACCOUNTS)
    ) u_bank (
        .clk         (clk),
        .rst         (rst),
        .rd_id       (id_reg),
        .rd_psw      (rd_psw),
        .rd_balance  (rd_balance),
        .lock_bits   (lock_bits),
        .wr_en       (wr_en),
        .wr_id       (wr_id),
        .wr_psw_en   (wr_psw_en),
        .wr_psw      (wr_psw),
        .wr_balance  (wr_balance),
        .wr_clr_lock (wr_clr_lock),
        .lock_set    (lock_set),
        .lock_id     (id_reg)
    );

    assign abort     = !bus.card_in || bus.timeout;
    assign tries_inc = tries_reg + TRY_W'(1);
    // Out-of-range card ids are handled exactly like a locked account.
    assign card_ok   = ({1'b0, bus.card_id} < NUM_ID) && !lock_bits[bus.card_id];
    assign prog_ok   = (state_reg == ST_IDLE) && !bus.card_in &&
                       ({1'b0, bus.prog_id} < NUM_ID);

    always_comb begin
        state_next       = state_reg;
        id_next          = id_reg;
        tries_next       = tries_reg;
        psw_ok_next      = 1'b0;
        wrong_psw_next   = 1'b0;
        card_locked_next = 1'b0;
        commit_ack_next  = 1'b0;
        prog_err_next    = 1'b0;
        commit           = 1'b0;
        lock_set         = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.card_in) begin
                    if (!card_ok) begin
                        card_locked_next = 1'b1;
                        state_next       = ST_REJECT;
                    end else begin
                        id_next    = bus.card_id;
                        tries_next = '0;
                        state_next = ST_AUTH;
                    end
                end
            end
            ST_AUTH: begin
                // Abort wins over a same-cycle password attempt.
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (bus.psw_valid) begin
                    if (bus.psw_in == rd_psw) begin
                        psw_ok_next = 1'b1;
                        state_next  = ST_SESSION;
                    end else if (tries_inc == TRY_MAX) begin
                        card_locked_next = 1'b1;
                        lock_set         = 1'b1;
                        state_next       = ST_REJECT;
                    end else begin
                        wrong_psw_next = 1'b1;
                        tries_next     = tries_inc;
                    end
                end
            end
            ST_SESSION: begin
                if (abort) begin
                    state_next = ST_IDLE;
                end else if (bus.op_done) begin
                    commit          = 1'b1;
                    commit_ack_next = 1'b1;
                end
            end
            ST_REJECT: begin
                if (!bus.card_in) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        if (bus.prog_en && !prog_ok) begin
            prog_err_next = 1'b1;
        end

        // Commit (SESSION) and provisioning (IDLE) are mutually exclusive.
        wr_en       = commit || (bus.prog_en && prog_ok);
        wr_id       = commit ? id_reg : bus.prog_id;
        wr_psw_en   = !commit;
        wr_clr_lock = !commit;
        wr_psw      = bus.prog_psw;
        wr_balance  = commit ? bus.new_balance : bus.prog_balance;

        // Balance register follows the table, bypassing a commit in flight so
        // the new value is visible together with commit_ack.
        session_active_next = (state_next == ST_SESSION);
        balance_next        = '0;
        if (state_next == ST_SESSION) begin
            balance_next = commit ? bus.new_balance : rd_balance;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg          <= ST_IDLE;
            id_reg             <= '0;
            tries_reg          <= '0;
            psw_ok_reg         <= 1'b0;
            wrong_psw_reg      <= 1'b0;
            card_locked_reg    <= 1'b0;
            commit_ack_reg     <= 1'b0;
            session_active_reg <= 1'b0;
            prog_err_reg       <= 1'b0;
            balance_reg        <= '0;
        end else begin
            state_reg          <= state_next;
            id_reg             <= id_next;
            tries_reg          <= tries_next;
            psw_ok_reg         <= psw_ok_next;
            wrong_psw_reg      <= wrong_psw_next;
            card_locked_reg    <= card_locked_next;
            commit_ack_reg     <= commit_ack_next;
            session_active_reg <= session_active_next;
            prog_err_reg       <= prog_err_next;
            balance_reg        <= balance_next;
        end
    end

    assign bus.psw_ok          = psw_ok_reg;
    assign bus.wrong_psw       = wrong_psw_reg;
    assign bus.card_locked     = card_locked_reg;
    assign bus.commit_ack      = commit_ack_reg;
    assign bus.session_active  = session_active_reg;
    assign bus.prog_err        = prog_err_reg;
    assign bus.current_balance = balance_reg;

endmodule

// File: tb/tb_atm_account_server.sv
// Self-checking bench for atm_account_server: table of per-cycle stimulus and
// expected registered outputs, run through a scoreboard queue, followed by a
// hand-written asynchronous-reset sequence.
module tb_atm_account_server;
    import atm_pkg::*;

    typedef struct packed {
        logic        ci;
        logic [1:0]  cid;
        logic        to;
        logic        pv;
        logic [15:0] psw;
        logic        od;
        logic [19:0] nb;
        logic        pe;
        logic [1:0]  pid;
        logic [15:0] ppsw;
        logic [19:0] pbal;
    } stim_t;

    typedef struct packed {
        logic        ok;
        logic        wr;
        logic        lk;
        logic [19:0] bal;
        logic        ack;
        logic        sa;
        logic        perr;
    } exp_t;

    typedef struct {
        string name;
        stim_t s;
        exp_t  e;
    } vec_t;

    typedef struct {
        string name;
        exp_t  e;
    } sb_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    sb_t  sb_q[$];

    atm_account_server_if #(.BALANCE_WIDTH(20), .ID_WIDTH(2), .PSW_WIDTH(16)) bus ();

    atm_account_server #(
        .BALANCE_WIDTH(20), .NUM_ACCOUNTS(4), .ID_WIDTH(2), .PSW_WIDTH(16), .MAX_TRIES(3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- stimulus / expectation constructors ----------------
    function automatic stim_t s_none();
        s_none = '0;
    endfunction
    function automatic stim_t s_card(input logic [1:0] id);
        s_card     = '0;
        s_card.ci  = 1'b1;
        s_card.cid = id;
    endfunction
    function automatic stim_t s_psw(input logic [1:0] id, input logic [15:0] p);
        s_psw     = s_card(id);
        s_psw.pv  = 1'b1;
        s_psw.psw = p;
    endfunction
    function automatic stim_t s_op(input logic [1:0] id, input logic [19:0] nb);
        s_op    = s_card(id);
        s_op.od = 1'b1;
        s_op.nb = nb;
    endfunction
    function automatic stim_t s_prog(input logic ci, input logic [1:0] cid, input logic [1:0] pid,
                                     input logic [15:0] p, input logic [19:0] b);
        s_prog      = '0;
        s_prog.ci   = ci;
        s_prog.cid  = cid;
        s_prog.pe   = 1'b1;
        s_prog.pid  = pid;
        s_prog.ppsw = p;
        s_prog.pbal = b;
    endfunction
    function automatic stim_t with_to(input stim_t s);
        with_to    = s;
        with_to.to = 1'b1;
    endfunction

    function automatic exp_t e_none();
        e_none = '0;
    endfunction
    function automatic exp_t e_ok(input logic [19:0] b);
        e_ok     = '0;
        e_ok.ok  = 1'b1;
        e_ok.sa  = 1'b1;
        e_ok.bal = b;
    endfunction
    function automatic exp_t e_sess(input logic [19:0] b);
        e_sess     = '0;
        e_sess.sa  = 1'b1;
        e_sess.bal = b;
    endfunction
    function automatic exp_t e_ack(input logic [19:0] b);
        e_ack     = e_sess(b);
        e_ack.ack = 1'b1;
    endfunction
    function automatic exp_t e_wrong();
        e_wrong    = '0;
        e_wrong.wr = 1'b1;
    endfunction
    function automatic exp_t e_lock();
        e_lock    = '0;
        e_lock.lk = 1'b1;
    endfunction
    function automatic exp_t e_perr(input logic sa, input logic [19:0] b);
        e_perr      = '0;
        e_perr.perr = 1'b1;
        e_perr.sa   = sa;
        e_perr.bal  = b;
    endfunction

    // ---------------- drivers / checkers ----------------
    task automatic add(input string n, input stim_t s, input exp_t e);
        vec_t v;
        v.name = n;
        v.s    = s;
        v.e    = e;
        tbl.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        bus.card_in      = s.ci;
        bus.card_id      = s.cid;
        bus.timeout      = s.to;
        bus.psw_valid    = s.pv;
        bus.psw_in       = s.psw;
        bus.op_done      = s.od;
        bus.new_balance  = s.nb;
        bus.prog_en      = s.pe;
        bus.prog_id      = s.pid;
        bus.prog_psw     = s.ppsw;
        bus.prog_balance = s.pbal;
    endtask

    function automatic exp_t sample();
        sample.ok   = bus.psw_ok;
        sample.wr   = bus.wrong_psw;
        sample.lk   = bus.card_locked;
        sample.bal  = bus.current_balance;
        sample.ack  = bus.commit_ack;
        sample.sa   = bus.session_active;
        sample.perr = bus.prog_err;
    endfunction

    task automatic check(input string n, input exp_t e);
        exp_t a;
        a = sample();
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got ok=%0b wr=%0b lk=%0b bal=%0d ack=%0b sa=%0b perr=%0b, want ok=%0b wr=%0b lk=%0b bal=%0d ack=%0b sa=%0b perr=%0b",
                     n, a.ok, a.wr, a.lk, a.bal, a.ack, a.sa, a.perr,
                     e.ok, e.wr, e.lk, e.bal, e.ack, e.sa, e.perr);
        end else begin
            $display("ok   %s: bal=%0d sa=%0b", n, a.bal, a.sa);
        end
    endtask

    // One clock per vector: drive at negedge, expectation queued, compared
    // #1 after the following posedge when the registered outputs update.
    task automatic apply(input vec_t v);
        sb_t item;
        sb_t got;
        @(negedge clk);
        drive(v.s);
        item.name = v.name;
        item.e    = v.e;
        sb_q.push_back(item);
        @(posedge clk);
        #1;
        got = sb_q.pop_front();
        check(got.name, got.e);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1;
        drive(s_none());
        #3 rst = 1'b0;
        #1 check("reset_state", e_none());
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // 1/2: provisioning, authentication, commit and back-to-back commits
        add("prog_id1",     s_prog(0, 0, 1, 16'h1234, 500),  e_none());
        add("prog_id2",     s_prog(0, 0, 2, 16'h2222, 1000), e_none());
        add("t1_insert",    s_card(1),             e_none());
        add("t1_auth",      s_psw(1, 16'h1234),    e_ok(500));
        add("t1_hold",      s_card(1),             e_sess(500));
        add("t2_commit",    s_op(1, 320),          e_ack(320));
        add("t2_hold",      s_card(1),             e_sess(320));
        add("t2_remove",    s_none(),              e_none());
        add("t2_reinsert",  s_card(1),             e_none());
        add("t2_reauth",    s_psw(1, 16'h1234),    e_ok(320));
        add("t2_b2b_a",     s_op(1, 100),          e_ack(100));
        add("t2_b2b_b",     s_op(1, 200),          e_ack(200));
        add("t2_b2b_hold",  s_card(1),             e_sess(200));
        add("t2_restore",   s_op(1, 320),          e_ack(320));
        add("t2_remove2",   s_none(),              e_none());
        // 3: lockout after MAX_TRIES wrong passwords
        add("t3_insert",    s_card(2),             e_none());
        add("t3_wrong1",    s_psw(2, 16'h0001),    e_wrong());
        add("t3_wrong2",    s_psw(2, 16'h0002),    e_wrong());
        add("t3_wrong3",    s_psw(2, 16'h0003),    e_lock());
        add("t3_rej_psw",   s_psw(2, 16'h2222),    e_none());
        add("t3_remove",    s_none(),              e_none());
`ifdef ATM_PERSISTENT_LOCKOUT_EN
        add("t3_reins_locked", s_card(2),          e_lock());
        add("t3_rej_psw2",  s_psw(2, 16'h2222),    e_none());
`else
        add("t3_reins_free", s_card(2),            e_none());
        add("t3_auth_free", s_psw(2, 16'h2222),    e_ok(1000));
`endif
        add("t3_remove2",   s_none(),              e_none());
        add("t3_reprog",    s_prog(0, 0, 2, 16'h2222, 1000), e_none());
        add("t3_insert3",   s_card(2),             e_none());
        add("t3_auth3",     s_psw(2, 16'h2222),    e_ok(1000));
        add("t3_remove3",   s_none(),              e_none());
        // try counter cleared on every new insertion
        add("tr_insert",    s_card(2),             e_none());
        add("tr_wrong1",    s_psw(2, 16'h0bad),    e_wrong());
        add("tr_wrong2",    s_psw(2, 16'h0bad),    e_wrong());
        add("tr_abort",     s_none(),              e_none());
        add("tr_insert2",   s_card(2),             e_none());
        add("tr_wrong3",    s_psw(2, 16'h0bad),    e_wrong());
        add("tr_wrong4",    s_psw(2, 16'h0bad),    e_wrong());
        add("tr_auth",      s_psw(2, 16'h2222),    e_ok(1000));
        add("tr_remove",    s_none(),              e_none());
        // 4: abort beats a same-cycle commit or password
        add("t4_insert",    s_card(1),             e_none());
        add("t4_auth",      s_psw(1, 16'h1234),    e_ok(320));
        add("t4_op_to",     with_to(s_op(1, 0)),   e_none());
        add("t4_remove",    s_none(),              e_none());
        add("t4_insert2",   s_card(1),             e_none());
        add("t4_psw_to",    with_to(s_psw(1, 16'h1234)), e_none());
        add("t4_insert3",   s_card(1),             e_none());
        add("t4_auth3",     s_psw(1, 16'h1234),    e_ok(320));
        add("t4_remove3",   s_none(),              e_none());
        // 5: provisioning only from IDLE with no card present
        add("t5_insert",    s_card(1),             e_none());
        add("t5_auth",      s_psw(1, 16'h1234),    e_ok(320));
        add("t5_prog_sess", s_prog(1, 1, 1, 16'h0000, 9), e_perr(1, 320));
        add("t5_remove",    s_none(),              e_none());
        add("t5_prog_id3",  s_prog(0, 0, 3, 16'h3333, 77), e_none());
        add("t5_insert3",   s_card(3),             e_none());
        add("t5_auth3",     s_psw(3, 16'h3333),    e_ok(77));
        add("t5_remove3",   s_none(),              e_none());
        add("t5_prog_card", s_prog(1, 1, 0, 16'h0000, 9), e_perr(0, 0));
        add("t5_abort",     s_none(),              e_none());
        add("t5_insert1",   s_card(1),             e_none());
        add("t5_auth1",     s_psw(1, 16'h1234),    e_ok(320));
        add("t5_remove1",   s_none(),              e_none());
        run_table();

        // 6: asynchronous reset in the middle of a session
        add("t6_insert",    s_card(1),             e_none());
        add("t6_auth",      s_psw(1, 16'h1234),    e_ok(320));
        add("t6_hold",      s_card(1),             e_sess(320));
        run_table();
        #2 rst = 1'b0;
        #1 check("t6_rst_async", e_none());
        drive(s_none());
        @(negedge clk);
        rst = 1'b1;
        add("t6_idle",      s_none(),              e_none());
        add("t6_insert2",   s_card(1),             e_none());
        add("t6_auth_zero", s_psw(1, 16'h0000),    e_ok(0));
        add("t6_remove",    s_none(),              e_none());
        run_table();

        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/atm_account_server.md
Name: atm_account_server

Overview:
- Bank-side responder for the ATM session controller.
- Authenticates an inserted card's password against a small on-chip account table and sources `current_balance` and `wrong_psw` to the controller.
- Accepts committed balance write-backs when the controller signals `op_done`.
- Tracks per-account failed-attempt lockout, and provides a provisioning port for loading accounts while no session is active.

Parameters:
- BALANCE_WIDTH, 20, width of balance values; matches the session controller.
- NUM_ACCOUNTS, 4, number of account entries.
- ID_WIDTH, 2, card/account index width; must satisfy 2**ID_WIDTH >= NUM_ACCOUNTS.
- PSW_WIDTH, 16, password width.
- MAX_TRIES, 3, consecutive wrong passwords allowed before rejection.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- card_in  in  1  card present; level signal
- card_id  in  ID_WIDTH  account index; sampled on card acceptance
- timeout  in  1  session timer expiry; aborts the session
- psw_valid  in  1  one-cycle strobe; `psw_in` is valid
- psw_in  in  PSW_WIDTH  password attempt
- op_done  in  1  commit strobe from the controller
- new_balance  in  BALANCE_WIDTH  balance to store on commit
- prog_en  in  1  provisioning write strobe
- prog_id  in  ID_WIDTH  provisioning target account
- prog_psw  in  PSW_WIDTH  provisioning password
- prog_balance  in  BALANCE_WIDTH  provisioning balance; write also clears the lock bit
- psw_ok  out  1  one-cycle pulse on password match
- wrong_psw  out  1  one-cycle pulse on password mismatch
- card_locked  out  1  one-cycle pulse on rejection (locked account or tries exhausted)
- current_balance  out  BALANCE_WIDTH  balance of the active account
- commit_ack  out  1  one-cycle pulse; write-back done
- session_active  out  1  high while in SESSION
- prog_err  out  1  one-cycle pulse; provisioning ignored

Behaviour:
- Reset: state IDLE. All balances, passwords, lock bits, try counter, and latched id are 0. All outputs are 0.
- All outputs are registered.

States:
- **IDLE**
  - `card_in`=1 and the account indexed by `card_id` has its lock bit set: pulse `card_locked` next cycle, go to REJECT.
  - `card_in`=1 otherwise: latch `card_id`, clear the try counter, go to AUTH.
  - `card_id` >= NUM_ACCOUNTS: treated as locked.
- **AUTH**
  - `psw_valid` and `psw_in` equals the stored password: `psw_ok` one cycle later, go to SESSION.
  - `psw_valid` and mismatch: increment tries; `wrong_psw` pulses one cycle later.
  - When tries reaches MAX_TRIES: pulse `card_locked` instead of `wrong_psw`, set the account's lock bit, go to REJECT.
- **SESSION**
  - `session_active`=1.
  - `current_balance` = stored balance of the latched account. It is valid from the `psw_ok` cycle onward and is 0 outside SESSION.
  - `op_done` at cycle N: `new_balance` is stored at N+1, `current_balance` reflects it at N+1, and `commit_ack` pulses at N+1.
  - `op_done` on back-to-back cycles: each commit is applied; the last one wins.
- **REJECT**
  - Outputs idle.
  - Go to IDLE when `card_in`=0.

Abort and priority rules:
- In AUTH or SESSION, `card_in`=0 or `timeout`=1 means next state IDLE.
- Abort has priority over a same-cycle `psw_valid` or `op_done`: no write, no pulse.
- The try counter is not retained across sessions.

Provisioning:
- `prog_en` is accepted only when state is IDLE and `card_in`=0. It writes the password and balance and clears the lock bit next cycle.
- In any other condition the write is ignored and `prog_err` pulses next cycle.
- `prog_id` >= NUM_ACCOUNTS: ignored, with `prog_err`.

Reset mid-session: returns immediately to reset values. Account contents are lost, because storage is flops.

Width rules: `new_balance` is stored verbatim. The server does no arithmetic on balances; range checking is the controller's job.

Optional Feature:
- Macro: ATM_PERSISTENT_LOCKOUT_EN.
- Defined: exhausting MAX_TRIES sets the account lock bit. Later insertions of that card get `card_locked` from IDLE until the account is re-provisioned.
- Undefined: no lock bits exist. Exhausting tries pulses `card_locked` and goes to REJECT, but the account stays usable on the next insertion.

Decomposition:
- Package `atm_pkg` holds:
  - the state encoding (IDLE, AUTH, SESSION, REJECT);
  - default widths BALANCE_WIDTH, PSW_WIDTH, ID_WIDTH, shared with the session controller;
  - MAX_TRIES default.
- One sub-module, `atm_account_bank`:
  - NUM_ACCOUNTS x (password, balance, lock) register file;
  - one asynchronous read port indexed by the latched id;
  - one write port, muxed between the commit path and the provisioning path;
  - lock-set input.
- The FSM, try counter, and output pulse registers live in the top module.

Test Plan:
1. Provision id 1 (psw 0x1234, bal 500). Insert card 1, `psw_valid` with 0x1234 → `psw_ok` one cycle later, `current_balance`=500, `session_active`=1.
2. In session, `op_done` with `new_balance`=320 → `commit_ack` next cycle, `current_balance`=320. Remove card, reinsert, authenticate → 320.
3. Three wrong passwords on id 2 → `wrong_psw`, `wrong_psw`, `card_locked`.
   - With the macro: reinsertion gives `card_locked` from IDLE; re-provisioning id 2 unlocks it.
   - Without the macro: the next insertion authenticates.
4. `op_done` and `timeout` asserted in the same cycle with `new_balance`=0 → no `commit_ack`, state IDLE, stored balance unchanged.
5. `prog_en` during SESSION → `prog_err` pulse, table unchanged. `prog_en` with `prog_id`=3 in IDLE → accepted.
6. Assert `rst` low mid-SESSION → all outputs 0 immediately, state IDLE, balances 0.
